// File: rtl/seven_segment_reader.sv
// seven_segment_reader: samples a multiplexed active-low segment/anode bus and
// rebuilds per-digit hex frames delivered over valid/ready.
// Optional build macro SEVSEG_READER_ERR_EN: flag illegal patterns in frame_err
// and report a held multi-select as a bus fault through overflow.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] frame_bch,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overflow
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CPRE = CW'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS-1:0]   prev_sel;
    logic [6:0]              prev_seg;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] cap_bch;
    logic [NUM_DIGITS-1:0]   cap_blank, cap_err, seen, low;
    logic [IW-1:0]           idx;
    logic [3:0]              dec_bch;
    logic                    dec_blank, dec_err;
    logic                    one_low, multi, same, capture, frame_done, bus_fault;

    assign low        = ~digit_sel;
    assign multi      = (low & (low - NUM_DIGITS'(1))) != '0;
    assign one_low    = (low != '0) && !multi;
    assign same       = (digit_sel == prev_sel) && (segment == prev_seg);
    assign capture    = one_low && same && (cnt == CPRE);
    assign frame_done = &seen;

    // Position of the single low anode bit
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (low[i]) idx = IW'(i);
    end

    // Segment pattern to hex value with blank/illegal classification
    always_comb begin
        dec_bch   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (segment)
            7'b1000000: dec_bch = 4'h0;
            7'b1111001: dec_bch = 4'h1;
            7'b0100100: dec_bch = 4'h2;
            7'b0110000: dec_bch = 4'h3;
            7'b0011001: dec_bch = 4'h4;
            7'b0010010: dec_bch = 4'h5;
            7'b0000010: dec_bch = 4'h6;
            7'b1111000: dec_bch = 4'h7;
            7'b0000000: dec_bch = 4'h8;
            7'b0010000,
            7'b0011000: dec_bch = 4'h9;
            7'b0001000: dec_bch = 4'hA;
            7'b0000011: dec_bch = 4'hB;
            7'b1000110: dec_bch = 4'hC;
            7'b0100001: dec_bch = 4'hD;
            7'b0000110: dec_bch = 4'hE;
            7'b0001110: dec_bch = 4'hF;
            7'b1111111: dec_blank = 1'b1;
`ifdef SEVSEG_READER_ERR_EN
            default:    dec_err = 1'b1;
`else
            default:    dec_blank = 1'b1;
`endif
        endcase
    end

`ifdef SEVSEG_READER_ERR_EN
    logic [CW-1:0] mcnt;
    assign bus_fault = multi && same && (mcnt == CPRE);

    // Dwell counter for a multi-select held on the bus
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)
            mcnt <= '0;
        else
            mcnt <= (multi && same) ? ((mcnt == CMAX) ? mcnt : mcnt + CW'(1)) : '0;
    end
`else
    assign bus_fault = 1'b0;
`endif

    // Stability tracking, per-digit capture, frame assembly and handshake
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            prev_sel    <= '0;
            prev_seg    <= '0;
            cnt         <= '0;
            cap_bch     <= '0;
            cap_blank   <= '0;
            cap_err     <= '0;
            seen        <= '0;
            frame_bch   <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev_sel <= digit_sel;
            prev_seg <= segment;
            cnt      <= (one_low && same) ? ((cnt == CMAX) ? cnt : cnt + CW'(1)) : '0;
            if (capture) begin
                cap_bch[4*idx +: 4] <= dec_bch;
                cap_blank[idx]      <= dec_blank;
                cap_err[idx]        <= dec_err;
            end
            seen <= (frame_done ? '0 : seen) | (capture ? low : '0);
            if (frame_done && (!frame_valid || frame_ready)) begin
                frame_bch   <= cap_bch;
                frame_blank <= cap_blank;
                frame_err   <= cap_err;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
            if ((frame_done && frame_valid && !frame_ready) || bus_fault)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: scoreboard bench for a 2-digit reader, default build
module tb_seven_segment_reader;
    typedef struct packed {
        logic [7:0] bch;
        logic [1:0] blank;
        logic [1:0] err;
    } frame_t;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic [6:0] segment = 7'b1111111;
    logic [1:0] digit_sel = 2'b11;
    logic       frame_ready = 1'b1;
    logic [7:0] frame_bch;
    logic [1:0] frame_blank, frame_err;
    logic       frame_valid, overflow;

    frame_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0;
    logic       valid_acc = 1'b0;
    logic       watch = 1'b0;
    logic       changed = 1'b0;
    logic [7:0] bch_ref;
    logic [1:0] blank_ref;

    seven_segment_reader #(.NUM_DIGITS(2), .STABLE_CYCLES(4)) dut (
        .clock(clock), .reset_L(reset_L), .segment(segment), .digit_sel(digit_sel),
        .frame_bch(frame_bch), .frame_blank(frame_blank), .frame_err(frame_err),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: observe outputs at the falling edge, return 2 units after the rising edge
    task automatic tick();
        @(negedge clock);
        if (frame_valid) begin
            valid_acc = 1'b1;
            vcnt++;
        end
        if (watch && (!frame_valid || frame_bch !== bch_ref || frame_blank !== blank_ref))
            changed = 1'b1;
        @(posedge clock);
        #2;
    endtask

    task automatic hold(input logic [1:0] sel, input logic [6:0] seg, input int n);
        digit_sel = sel;
        segment   = seg;
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] bch, input logic [1:0] blank, input logic [1:0] err);
        frame_t f;
        f.bch   = bch;
        f.blank = blank;
        f.err   = err;
        exp_q.push_back(f);
    endtask

    // Monitor: every accepted frame is matched against the scoreboard
    initial begin
        frame_t f;
        forever begin
            @(negedge clock);
            if (reset_L && frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(exp_q.size()), 32'd1);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_bch", 32'(frame_bch), 32'(f.bch));
                    check("frame_blank", 32'(frame_blank), 32'(f.blank));
                    check("frame_err", 32'(frame_err), 32'(f.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_bch", 32'(frame_bch), 32'd0);
        check("rst_blank", 32'(frame_blank), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_L = 1'b1;
        tick();

        // Basic frame: digit0=5, digit1=0, consumer always ready
        push(8'h05, 2'b00, 2'b00);
        vcnt = 0;
        hold(2'b10, 7'b0010010, 4);
        hold(2'b01, 7'b1000000, 4);
        repeat (5) tick();
        check("t1_valid_pulse_cycles", 32'(vcnt), 32'd1);

        // Glitching digit1 never captures; stable hold then completes the frame
        hold(2'b10, 7'b0110000, 4);
        valid_acc = 1'b0;
        for (int i = 0; i < 10; i++)
            hold(2'b01, (i % 2 == 0) ? 7'b1111000 : 7'b0000000, 2);
        check("t2_glitch_no_frame", 32'(valid_acc), 32'd0);
        push(8'h43, 2'b00, 2'b00);
        hold(2'b01, 7'b0011001, 4);
        repeat (3) tick();

        // Blank digit, snapshot held stable while the consumer stalls
        frame_ready = 1'b0;
        push(8'h08, 2'b10, 2'b00);
        hold(2'b10, 7'b0000000, 4);
        hold(2'b01, 7'b1111111, 4);
        repeat (2) tick();
        bch_ref   = frame_bch;
        blank_ref = frame_blank;
        changed   = 1'b0;
        watch     = 1'b1;
        repeat (10) tick();
        watch = 1'b0;
        check("t3_stable", 32'(changed), 32'd0);
        check("t3_valid_held", 32'(frame_valid), 32'd1);
        check("t3_bch", 32'(frame_bch), 32'h08);
        check("t3_blank", 32'(frame_blank), 32'h2);
        frame_ready = 1'b1;
        tick();
        check("t3_valid_drop", 32'(frame_valid), 32'd0);

        // Overflow: second frame while first is unaccepted is dropped
        frame_ready = 1'b0;
        push(8'h21, 2'b00, 2'b00);
        hold(2'b10, 7'b1111001, 4);
        hold(2'b01, 7'b0100100, 4);
        hold(2'b10, 7'b0000110, 4);
        hold(2'b01, 7'b0001110, 4);
        repeat (2) tick();
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_retained_bch", 32'(frame_bch), 32'h21);
        check("t4_retained_valid", 32'(frame_valid), 32'd1);
        hold(2'b01, 7'b1111000, 4);
        hold(2'b10, 7'b0000000, 2);
        #1 reset_L = 1'b0;
        #1;
        check("t4_async_valid", 32'(frame_valid), 32'd0);
        check("t4_async_overflow", 32'(overflow), 32'd0);
        check("t4_async_bch", 32'(frame_bch), 32'd0);
        check("t4_async_blank", 32'(frame_blank), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset_L     = 1'b1;
        frame_ready = 1'b1;

        // After reset both digits must be captured again; alternate 9 pattern
        valid_acc = 1'b0;
        hold(2'b10, 7'b0011000, 4);
        repeat (2) tick();
        check("t4_no_frame_after_reset", 32'(valid_acc), 32'd0);
        push(8'hA9, 2'b00, 2'b00);
        hold(2'b01, 7'b0001000, 4);
        repeat (3) tick();

        // Illegal pattern decodes as blank in this build
        push(8'hB0, 2'b01, 2'b00);
        hold(2'b10, 7'b1010101, 4);
        hold(2'b01, 7'b0000011, 4);
        repeat (3) tick();

        // Recapture keeps the last value; multi-select is idle
        hold(2'b10, 7'b0000010, 4);
        hold(2'b10, 7'b1000110, 4);
        valid_acc = 1'b0;
        hold(2'b00, 7'b0000000, 10);
        check("t6_multi_no_frame", 32'(valid_acc), 32'd0);
        check("t6_multi_no_overflow", 32'(overflow), 32'd0);
        push(8'hDC, 2'b00, 2'b00);
        hold(2'b01, 7'b0100001, 4);
        repeat (4) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
